// File: rtl/bb_pid_pkg.sv
// Shared types, default sizing and the saturation helper for the multi-axis PID.
// Integrator and accumulator widths are derived from the data and gain widths.
package bb_pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ERR   = 3'd2,
    S_PTERM = 3'd3,
    S_ITERM = 3'd4,
    S_DTERM = 3'd5,
    S_WRITE = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  // Integrator/derivative need two guard bits over the data width.
  function automatic int int_width(input int dw);
    return dw + 2;
  endfunction

  // Three products of (DW+2)x(GW+1) bits summed without overflow.
  function automatic int acc_width(input int dw, input int gw);
    return dw + gw + 4;
  endfunction

  localparam int PID_CH    = 4;
  localparam int PID_DW    = 16;
  localparam int PID_GW    = 16;
  localparam int PID_FRAC  = 8;
  localparam int PID_INT_W = int_width(PID_DW);
  localparam int PID_ACC_W = acc_width(PID_DW, PID_GW);

  function automatic logic signed [63:0] sat_sym(input logic signed [63:0] v,
                                                 input logic signed [63:0] lim);
    logic signed [63:0] res;
    if (v > lim) begin
      res = lim;
    end else if (v < -lim) begin
      res = -lim;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/bb_pid_mac.sv
// Registered signed multiply-accumulate shared by all PID terms and channels.
// Operand b is an unsigned gain; i_clr with i_add loads a fresh product.
module bb_pid_mac
  import bb_pid_pkg::*;
#(
  parameter int OPW  = PID_INT_W,
  parameter int GW   = PID_GW,
  parameter int ACCW = PID_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_add,
  input  logic signed [OPW-1:0]  i_a,
  input  logic        [GW-1:0]   i_b,
  output logic signed [ACCW-1:0] o_acc
);

  logic signed [OPW+GW:0] w_prod;
  logic signed [ACCW-1:0] r_acc;

  assign w_prod = (OPW + GW + 1)'(i_a) * (OPW + GW + 1)'($signed({1'b0, i_b}));

  // accumulator: load, add or hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr && i_add) begin
      r_acc <= ACCW'(w_prod);
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + ACCW'(w_prod);
    end else begin
      r_acc <= r_acc;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/bb_pid_multi.sv
// Time-multiplexed multi-axis PID with anti-windup and output saturation.
// Define DERIV_ON_MEAS_EN to take the derivative on measurement instead of error.
module bb_pid_multi
  import bb_pid_pkg::*;
#(
  parameter int CH   = PID_CH,
  parameter int DW   = PID_DW,
  parameter int GW   = PID_GW,
  parameter int FRAC = PID_FRAC,
  parameter int IMAX = 8192,
  parameter int OMAX = 30000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear_int,
  input  logic [CH*DW-1:0] target,
  input  logic [CH*DW-1:0] measured,
  input  logic [CH*GW-1:0] kp,
  input  logic [CH*GW-1:0] ki,
  input  logic [CH*GW-1:0] kd,
  output logic             busy,
  output logic             done,
  output logic [CH*DW-1:0] out
);

  localparam int IW   = int_width(DW);
  localparam int ACCW = acc_width(DW, GW);
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;

  state_t r_state, w_next;
  logic [CHW-1:0]    r_ch;
  logic [CH*DW-1:0]  r_tgt, r_meas, r_out;
  logic [CH*GW-1:0]  r_kp, r_ki, r_kd;
  logic signed [IW-1:0] r_integ [CH];
`ifdef DERIV_ON_MEAS_EN
  logic signed [DW-1:0] r_mprev [CH];
`else
  logic signed [DW:0]   r_eprev [CH];
`endif
  logic signed [DW:0]   r_e;
  logic signed [IW-1:0] r_icl, r_d;
  logic r_busy, r_done, r_clr_pend;

  logic signed [DW-1:0]   w_tgt, w_meas, w_out_ch;
  logic signed [DW:0]     w_e;
  logic signed [IW:0]     w_icand;
  logic signed [IW-1:0]   w_icl, w_d, w_mul_a;
  logic [GW-1:0]          w_mul_b;
  logic                   w_mac_clr, w_mac_add, w_clr_now;
  logic signed [ACCW-1:0] w_acc;

  assign w_tgt   = $signed(r_tgt[r_ch*DW +: DW]);
  assign w_meas  = $signed(r_meas[r_ch*DW +: DW]);
  assign w_e     = (DW + 1)'(w_tgt) - (DW + 1)'(w_meas);
  assign w_icand = (IW + 1)'(r_integ[r_ch]) + (IW + 1)'(w_e);
  assign w_icl   = IW'(sat_sym(64'(w_icand), 64'(IMAX)));
`ifdef DERIV_ON_MEAS_EN
  assign w_d     = IW'(r_mprev[r_ch]) - IW'(w_meas);
`else
  assign w_d     = IW'(w_e) - IW'(r_eprev[r_ch]);
`endif
  assign w_out_ch = DW'(sat_sym(64'(w_acc) >>> FRAC, 64'(OMAX)));

  // A clear seen while busy is deferred until the run has committed its history.
  assign w_clr_now = ((r_state == S_IDLE) && clear_int) ||
                     ((r_state == S_DONE) && (r_clr_pend || clear_int));

  // state register with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
    end
  end

  // next-state sequencing: five cycles per channel
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
        else       w_next = S_IDLE;
      end
      S_LOAD:  w_next = S_ERR;
      S_ERR:   w_next = S_PTERM;
      S_PTERM: w_next = S_ITERM;
      S_ITERM: w_next = S_DTERM;
      S_DTERM: w_next = S_WRITE;
      S_WRITE: begin
        if (r_ch == CHW'(CH - 1)) w_next = S_DONE;
        else                      w_next = S_ERR;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // multiplier operand selection per term
  always_comb begin
    w_mul_a   = '0;
    w_mul_b   = '0;
    w_mac_clr = 1'b0;
    w_mac_add = 1'b0;
    case (r_state)
      S_PTERM: begin
        w_mul_a   = IW'(r_e);
        w_mul_b   = r_kp[r_ch*GW +: GW];
        w_mac_clr = 1'b1;
        w_mac_add = 1'b1;
      end
      S_ITERM: begin
        w_mul_a   = r_icl;
        w_mul_b   = r_ki[r_ch*GW +: GW];
        w_mac_add = 1'b1;
      end
      S_DTERM: begin
        w_mul_a   = r_d;
        w_mul_b   = r_kd[r_ch*GW +: GW];
        w_mac_add = 1'b1;
      end
      default: begin
        w_mul_a   = '0;
        w_mul_b   = '0;
      end
    endcase
  end

  bb_pid_mac #(.OPW(IW), .GW(GW), .ACCW(ACCW)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_mac_clr),
    .i_add (w_mac_add),
    .i_a   (w_mul_a),
    .i_b   (w_mul_b),
    .o_acc (w_acc)
  );

  // input latch, per-channel error stage, output write and channel counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ch       <= '0;
      r_tgt      <= '0;
      r_meas     <= '0;
      r_kp       <= '0;
      r_ki       <= '0;
      r_kd       <= '0;
      r_e        <= '0;
      r_icl      <= '0;
      r_d        <= '0;
      r_out      <= '0;
      r_clr_pend <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_tgt  <= target;
          r_meas <= measured;
          r_kp   <= kp;
          r_ki   <= ki;
          r_kd   <= kd;
          r_ch   <= '0;
        end
        S_ERR: begin
          r_e   <= w_e;
          r_icl <= w_icl;
          r_d   <= w_d;
        end
        S_WRITE: begin
          r_out[r_ch*DW +: DW] <= w_out_ch;
          if (r_ch != CHW'(CH - 1)) r_ch <= r_ch + CHW'(1);
        end
        default: r_ch <= r_ch;
      endcase
      if (r_state == S_DONE)                        r_clr_pend <= 1'b0;
      else if (clear_int && (r_state != S_IDLE))    r_clr_pend <= 1'b1;
    end
  end

  // per-channel integrator and derivative history
  always_ff @(posedge clk) begin
    if (!rst_n || w_clr_now) begin
      for (int i = 0; i < CH; i++) begin
        r_integ[i] <= '0;
`ifdef DERIV_ON_MEAS_EN
        r_mprev[i] <= '0;
`else
        r_eprev[i] <= '0;
`endif
      end
    end else if (r_state == S_WRITE) begin
      r_integ[r_ch] <= r_icl;
`ifdef DERIV_ON_MEAS_EN
      r_mprev[r_ch] <= w_meas;
`else
      r_eprev[r_ch] <= r_e;
`endif
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign out  = r_out;

endmodule

// File: tb/tb_bb_pid_multi.sv
// Directed plus randomized bench for bb_pid_multi against a behavioural PID model.
module tb_bb_pid_multi;

  localparam int CH   = 4;
  localparam int DW   = 16;
  localparam int GW   = 16;
  localparam int IMAX = 1000;
  localparam int OMAX = 30000;
  localparam int LAT  = 5 * CH + 2;

  logic clk = 1'b0;
  logic rst_n, start, clear_int, busy, done;
  logic [CH*DW-1:0] target, measured, out;
  logic [CH*GW-1:0] kp, ki, kd;

  int checks = 0;
  int failures = 0;

  int     t_v [CH], m_v [CH], kp_v [CH], ki_v [CH], kd_v [CH];
  longint h_integ [CH], h_eprev [CH], h_mprev [CH];
  longint exp_out [CH];

  always #10 clk = ~clk;

  bb_pid_multi #(.CH(CH), .DW(DW), .GW(GW), .FRAC(8), .IMAX(IMAX), .OMAX(OMAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_int(clear_int),
    .target(target), .measured(measured), .kp(kp), .ki(ki), .kd(kd),
    .busy(busy), .done(done), .out(out)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input longint lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic logic signed [63:0] out_ch(input int ch);
    logic [CH*DW-1:0] tmp;
    tmp = out;
    return 64'($signed(tmp[ch*DW +: DW]));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < CH; i++) begin
      h_integ[i] = 0; h_eprev[i] = 0; h_mprev[i] = 0;
    end
  endtask

  // PID law from first principles: floor division for the fixed-point scale
  task automatic model_run();
    longint e, ic, d, acc, q;
    for (int i = 0; i < CH; i++) begin
      e  = longint'(t_v[i]) - longint'(m_v[i]);
      ic = clamp(h_integ[i] + e, IMAX);
`ifdef DERIV_ON_MEAS_EN
      d  = -(longint'(m_v[i]) - h_mprev[i]);
`else
      d  = e - h_eprev[i];
`endif
      acc = longint'(kp_v[i]) * e + longint'(ki_v[i]) * ic + longint'(kd_v[i]) * d;
      q = acc / 256;
      if ((acc % 256 != 0) && (acc < 0)) q = q - 1;
      exp_out[i] = clamp(q, OMAX);
      h_integ[i] = ic;
      h_eprev[i] = e;
      h_mprev[i] = m_v[i];
    end
  endtask

  task automatic drive();
    for (int i = 0; i < CH; i++) begin
      target[i*DW +: DW]   = 16'(t_v[i]);
      measured[i*DW +: DW] = 16'(m_v[i]);
      kp[i*GW +: GW]       = 16'(kp_v[i]);
      ki[i*GW +: GW]       = 16'(ki_v[i]);
      kd[i*GW +: GW]       = 16'(kd_v[i]);
    end
  endtask

  task automatic set_all(input int t, input int m, input int p, input int ig, input int dg);
    for (int i = 0; i < CH; i++) begin
      t_v[i] = t; m_v[i] = m; kp_v[i] = p; ki_v[i] = ig; kd_v[i] = dg;
    end
    drive();
  endtask

  task automatic pulse_clear();
    clear_int = 1'b1;
    @(posedge clk); #1;
    clear_int = 1'b0;
    model_clear();
  endtask

  // One run: start at cycle 0, per-cycle busy/done timing, outputs on done.
  task automatic run_pid(input string tag, input bit clr_start, input int clr_cyc,
                         input int rst_cyc, input bit restart);
    bit aborted;
    aborted = 1'b0;
    drive();
    if (clr_start) model_clear();
    model_run();
    start = 1'b1;
    clear_int = clr_start;
    @(posedge clk); #1;
    start = 1'b0;
    clear_int = 1'b0;
    for (int k = 1; k <= LAT + 8; k++) begin
      aborted = (rst_cyc > 0) && (k > rst_cyc);
      chk($sformatf("%s busy c%0d", tag, k), 64'(busy), 64'(!aborted && (k <= LAT)));
      chk($sformatf("%s done c%0d", tag, k), 64'(done), 64'(!aborted && (k == LAT)));
      if (k == LAT && !aborted)
        for (int c = 0; c < CH; c++)
          chk($sformatf("%s out%0d", tag, c), out_ch(c), 64'(exp_out[c]));
      if (aborted && k == rst_cyc + 1)
        chk($sformatf("%s out after reset", tag), 64'(out), 64'(0));
      start     = restart && (k == 3 || k == 10);
      clear_int = (k == clr_cyc);
      rst_n     = !(k == rst_cyc);
      @(posedge clk); #1;
    end
    start = 1'b0; clear_int = 1'b0; rst_n = 1'b1;
    if (clr_cyc > 0 || rst_cyc > 0) model_clear();
  endtask

  initial begin
    int lim, ccyc;
    bit cst;
    rst_n = 1'b0; start = 1'b0; clear_int = 1'b0;
    set_all(0, 0, 0, 0, 0);
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset out", 64'(out), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_all(100, 40, 256, 0, 0);
    run_pid("p_only", 1'b0, 0, 0, 1'b0);
    chk("p_only const", out_ch(0), 64'(60));

    pulse_clear();
    set_all(600, 0, 0, 256, 0);
    run_pid("i_run1", 1'b0, 0, 0, 1'b0);
    chk("i_run1 const", out_ch(1), 64'(600));
    run_pid("i_run2", 1'b0, 0, 0, 1'b0);
    chk("i_run2 clamp", out_ch(2), 64'(1000));
    run_pid("i_run3", 1'b0, 0, 0, 1'b0);
    chk("i_run3 clamp", out_ch(3), 64'(1000));
    pulse_clear();
    set_all(10, 0, 0, 256, 0);
    run_pid("i_clr", 1'b0, 0, 0, 1'b0);
    chk("i_clr const", out_ch(0), 64'(10));

    set_all(10000, 0, 2048, 0, 0);
    run_pid("sat_pos", 1'b0, 0, 0, 1'b0);
    chk("sat_pos const", out_ch(0), 64'(30000));
    set_all(-10000, 0, 2048, 0, 0);
    run_pid("sat_neg", 1'b0, 0, 0, 1'b0);
    chk("sat_neg const", out_ch(0), -64'sd30000);
    set_all(-1, 0, 128, 0, 0);
    run_pid("trunc", 1'b0, 0, 0, 1'b0);
    chk("trunc const", out_ch(0), -64'sd1);

    pulse_clear();
    set_all(0, 0, 0, 0, 256);
    run_pid("d_run1", 1'b0, 0, 0, 1'b0);
    chk("d_run1 const", out_ch(0), 64'(0));
    set_all(0, -50, 0, 0, 256);
    run_pid("d_run2", 1'b0, 0, 0, 1'b0);
    chk("d_run2 const", out_ch(0), 64'(50));
    run_pid("d_run3", 1'b0, 0, 0, 1'b0);
    chk("d_run3 const", out_ch(0), 64'(0));
    pulse_clear();
    set_all(0, 0, 0, 0, 256);
    run_pid("d_step0", 1'b0, 0, 0, 1'b0);
    set_all(50, 0, 0, 0, 256);
    run_pid("d_step1", 1'b0, 0, 0, 1'b0);
`ifdef DERIV_ON_MEAS_EN
    chk("d_step const", out_ch(0), 64'(0));
`else
    chk("d_step const", out_ch(0), 64'(50));
`endif

    pulse_clear();
    set_all(100, 0, 0, 256, 0);
    run_pid("hs_pre", 1'b0, 0, 0, 1'b0);
    run_pid("hs_busy", 1'b0, 8, 0, 1'b1);
    chk("hs_busy const", out_ch(0), 64'(200));
    run_pid("hs_post", 1'b0, 0, 0, 1'b0);
    chk("hs_post const", out_ch(0), 64'(100));

    run_pid("rst_mid", 1'b0, 0, 12, 1'b0);
    run_pid("rst_after", 1'b0, 0, 0, 1'b0);
    chk("rst_after const", out_ch(0), 64'(100));
    run_pid("clr_start", 1'b1, 0, 0, 1'b0);
    chk("clr_start const", out_ch(0), 64'(100));

    for (int r = 0; r < 24; r++) begin
      lim = (r % 2 == 0) ? 3000 : 32767;
      for (int i = 0; i < CH; i++) begin
        t_v[i]  = int'($urandom_range(0, 2 * lim)) - lim;
        m_v[i]  = int'($urandom_range(0, 2 * lim)) - lim;
        kp_v[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
        ki_v[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
        kd_v[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 1023));
      end
      cst  = ($urandom_range(0, 4) == 0);
      ccyc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 21)) : 0;
      run_pid($sformatf("rand%0d", r), cst, ccyc, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
